bgm_output_mixer: RTL and testbench

- Downstream stage of the BGM tone generator: consumes its 1-bit PWM-gated melody and bass tone lines plus a 1-bit sound-effect line.
- Recovers per-channel amplitude by counting high cycles over fixed windows, then mixes with weights, fade gain, SFX ducking and master volume.
- Drives a single speaker pin through a first-order sigma-delta modulator.
- Owns the fade-in/fade-out state machine and holds the upstream sequencer in reset while silent, so music restarts from note 0.

---
 rtl/bgm_output_mixer.sv | 205 ++++++++++++++++++++
 tb/tb_bgm_output_mixer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bgm_output_mixer.sv
// Output stage for the BGM generator: recovers tone amplitudes from PWM lines,
// mixes them with fade/duck/volume gain and drives the speaker via sigma-delta.
`timescale 1ns/1ps
module bgm_output_mixer #(
    parameter int MELODY_WT  = 2,
    parameter int BASS_WT    = 1,
    parameter int DUCK_LEVEL = 64,
    parameter int FADE_TICK  = 390625
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       melody_in,
    input  logic       bass_in,
    input  logic       sfx_in,
    input  logic       sfx_active,
    input  logic       play_req,
    input  logic       stop_req,
    input  logic [7:0] master_vol,
    output logic       audio_pwm,
    output logic       amp_en,
    output logic       seq_rst_n,
    output logic       fade_busy,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FADE_IN  = 2'd1;
    localparam logic [1:0] ST_PLAY     = 2'd2;
    localparam logic [1:0] ST_FADE_OUT = 2'd3;

    localparam int              TICK_W    = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FADE_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [7:0]      DUCK_GAIN = 8'(DUCK_LEVEL);

    function automatic logic [9:0] sat10(input logic [18:0] x);
        return (x > 19'd1023) ? 10'd1023 : x[9:0];
    endfunction

    logic [7:0]        win_cnt_q, win_cnt_d;
    logic [8:0]        m_cnt_q, m_cnt_d, b_cnt_q, b_cnt_d, s_cnt_q, s_cnt_d;
    logic [8:0]        m_inc, b_inc, s_inc;
    logic [8:0]        m_s_q, m_s_d, b_s_q, b_s_d, s_s_q, s_s_d;
    logic              cap;
    logic              vld_p0_q, vld_p1_q, vld_p2_q;
    logic [9:0]        music_p1_q, music_p1_d;
    logic [7:0]        gain_p1_q, gain_p1_d;
    logic [8:0]        s_p1_q;
    logic [10:0]       mix_p2_q, mix_p2_d;
    logic [9:0]        sample_q, sample_d;
    logic [9:0]        acc_q, acc_d;
    logic [10:0]       mod_sum;
    logic              pwm_q, pwm_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        fade_q, fade_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              tick_hit;
    logic              amp_en_q, seq_rst_n_q, fade_busy_q;

    // Amplitude windows: counts include the input of the capture cycle itself
    always_comb begin
        win_cnt_d = win_cnt_q + 8'd1;
        cap       = (win_cnt_q == 8'hFF);
        m_inc     = m_cnt_q + {8'd0, melody_in};
        b_inc     = b_cnt_q + {8'd0, bass_in};
        s_inc     = s_cnt_q + {8'd0, sfx_in};
        m_cnt_d   = cap ? 9'd0 : m_inc;
        b_cnt_d   = cap ? 9'd0 : b_inc;
        s_cnt_d   = cap ? 9'd0 : s_inc;
        m_s_d     = cap ? m_inc : m_s_q;
        b_s_d     = cap ? b_inc : b_s_q;
        s_s_d     = cap ? s_inc : s_s_q;
    end

    // S1: weighted music sum and fade/duck gain
    always_comb begin
        music_p1_d = sat10(19'(m_s_q) * 19'(MELODY_WT) + 19'(b_s_q) * 19'(BASS_WT));
        gain_p1_d  = (sfx_active && (fade_q > DUCK_GAIN)) ? DUCK_GAIN : fade_q;
    end

    // S2: apply gain to music only, then add the unscaled effect level
    always_comb begin
        mix_p2_d = 11'((18'(music_p1_q) * 18'(gain_p1_q)) >> 8) + 11'(s_p1_q);
    end

    // S3: master volume with saturation to the modulator range
    always_comb begin
        sample_d = sat10((19'(mix_p2_q) * 19'(master_vol)) >> 8);
    end

    // First-order sigma-delta; silenced as soon as the FSM heads to IDLE
    always_comb begin
        mod_sum = {1'b0, acc_q} + {1'b0, sample_q};
        if (state_d == ST_IDLE) begin
            acc_d = 10'd0;
            pwm_d = 1'b0;
        end else begin
            acc_d = mod_sum[9:0];
            pwm_d = mod_sum[10];
        end
    end

    always_comb begin
        state_d  = state_q;
        fade_d   = fade_q;
        tick_d   = '0;
        tick_hit = (tick_q == TICK_LAST);
        case (state_q)
            ST_IDLE: begin
                fade_d = 8'd0;
                if (play_req && !stop_req) state_d = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (stop_req) begin
                    state_d = ST_FADE_OUT;
                end else if (fade_q == 8'd255) begin
                    state_d = ST_PLAY;
                end else if (tick_hit) begin
                    fade_d = fade_q + 8'd1;
                    if (fade_q == 8'd254) state_d = ST_PLAY;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            ST_PLAY: begin
                fade_d = 8'd255;
                if (stop_req) state_d = ST_FADE_OUT;
            end
            default: begin
                // Stop wins over a simultaneous play, so only a lone play re-enters FADE_IN
                if (play_req && !stop_req) begin
                    state_d = ST_FADE_IN;
                end else if (fade_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else if (tick_hit) begin
                    fade_d = fade_q - 8'd1;
                    if (fade_q == 8'd1) state_d = ST_IDLE;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_cnt_q   <= 8'd0;
            m_cnt_q     <= 9'd0;
            b_cnt_q     <= 9'd0;
            s_cnt_q     <= 9'd0;
            m_s_q       <= 9'd0;
            b_s_q       <= 9'd0;
            s_s_q       <= 9'd0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            music_p1_q  <= 10'd0;
            gain_p1_q   <= 8'd0;
            s_p1_q      <= 9'd0;
            mix_p2_q    <= 11'd0;
            sample_q    <= 10'd0;
            acc_q       <= 10'd0;
            pwm_q       <= 1'b0;
            state_q     <= ST_IDLE;
            fade_q      <= 8'd0;
            tick_q      <= '0;
            amp_en_q    <= 1'b0;
            seq_rst_n_q <= 1'b0;
            fade_busy_q <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            m_cnt_q   <= m_cnt_d;
            b_cnt_q   <= b_cnt_d;
            s_cnt_q   <= s_cnt_d;
            m_s_q     <= m_s_d;
            b_s_q     <= b_s_d;
            s_s_q     <= s_s_d;
            vld_p0_q  <= cap;
            vld_p1_q  <= vld_p0_q;
            vld_p2_q  <= vld_p1_q;
            if (vld_p0_q) begin
                music_p1_q <= music_p1_d;
                gain_p1_q  <= gain_p1_d;
                s_p1_q     <= s_s_q;
            end
            if (vld_p1_q) mix_p2_q <= mix_p2_d;
            if (vld_p2_q) sample_q <= sample_d;
            acc_q       <= acc_d;
            pwm_q       <= pwm_d;
            state_q     <= state_d;
            fade_q      <= fade_d;
            tick_q      <= tick_d;
            amp_en_q    <= (state_d != ST_IDLE);
            seq_rst_n_q <= (state_d != ST_IDLE);
            fade_busy_q <= (state_d == ST_FADE_IN) || (state_d == ST_FADE_OUT);
        end
    end

    assign audio_pwm = pwm_q;
    assign amp_en    = amp_en_q;
    assign seq_rst_n = seq_rst_n_q;
    assign fade_busy = fade_busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_bgm_output_mixer.sv
// Directed bench for bgm_output_mixer: expectations queued at stimulus time, popped on observation.
`timescale 1ns/1ps
module tb_bgm_output_mixer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       melody_in, bass_in, sfx_in, sfx_active;
    logic       play_req, stop_req;
    logic [7:0] master_vol;
    logic       audio_pwm, amp_en, seq_rst_n, fade_busy;
    logic [1:0] state;

    bgm_output_mixer #(
        .MELODY_WT (2),
        .BASS_WT   (1),
        .DUCK_LEVEL(64),
        .FADE_TICK (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .melody_in (melody_in),
        .bass_in   (bass_in),
        .sfx_in    (sfx_in),
        .sfx_active(sfx_active),
        .play_req  (play_req),
        .stop_req  (stop_req),
        .master_vol(master_vol),
        .audio_pwm (audio_pwm),
        .amp_en    (amp_en),
        .seq_rst_n (seq_rst_n),
        .fade_busy (fade_busy),
        .state     (state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string tag;
        int    lo;
        int    hi;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // {amp_en, seq_rst_n, fade_busy, state}
    localparam int CTL_FADE_IN  = 29;
    localparam int CTL_PLAY     = 26;
    localparam int CTL_FADE_OUT = 31;

    task automatic sb_push(input string tag, input int lo, input int hi);
        exp_t e;
        e.tag = tag;
        e.lo  = lo;
        e.hi  = hi;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input int obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            e.tag = "scoreboard_empty";
            e.lo  = -1;
            e.hi  = -1;
        end else begin
            e = sb_q.pop_front();
        end
        assert ((obs >= e.lo && obs <= e.hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", e.tag, obs, e.lo, e.hi);
        end
    endtask

    function automatic int outs_all();
        return int'({audio_pwm, amp_en, seq_rst_n, fade_busy, state});
    endfunction

    function automatic int ctl();
        return int'({amp_en, seq_rst_n, fade_busy, state});
    endfunction

    task automatic drive_random(input bit allow_req);
        melody_in  = 1'($urandom_range(0, 1));
        bass_in    = 1'($urandom_range(0, 1));
        sfx_in     = 1'($urandom_range(0, 1));
        sfx_active = 1'($urandom_range(0, 1));
        master_vol = 8'($urandom_range(0, 255));
        play_req   = allow_req ? 1'($urandom_range(0, 1)) : 1'b0;
        stop_req   = allow_req ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic pulse(input logic p, input logic s);
        play_req = p;
        stop_req = s;
        @(negedge sys_clk);
        play_req = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic count_pwm(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge sys_clk);
            c += int'(audio_pwm);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int bound, output int n);
        n = 0;
        while (state !== target && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
    endtask

    task automatic mix_case(input string tag, input logic m, input logic b, input logic s,
                            input logic act, input logic [7:0] vol, input int expv,
                            input int settle);
        int c;
        melody_in  = m;
        bass_in    = b;
        sfx_in     = s;
        sfx_active = act;
        master_vol = vol;
        sb_push(tag, expv - 1, expv + 1);
        repeat (settle) @(negedge sys_clk);
        count_pwm(1024, c);
        sb_check(c);
    endtask

    initial begin
        int pwm_cnt;
        int on_cnt;
        int n;

        sys_rst_n = 1'b0;
        melody_in = 1'b0; bass_in = 1'b0; sfx_in = 1'b0; sfx_active = 1'b0;
        play_req = 1'b0; stop_req = 1'b0; master_vol = 8'd255;

        // Held in reset with random activity on every input
        for (int i = 0; i < 3; i++) begin
            sb_push("reset_outs", 0, 0);
            repeat (4) begin
                @(negedge sys_clk);
                drive_random(1'b1);
            end
            sb_check(outs_all());
        end

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        play_req  = 1'b0;
        stop_req  = 1'b0;
        sb_push("idle_pwm", 0, 0);
        sb_push("idle_enables", 0, 0);
        pwm_cnt = 0;
        on_cnt  = 0;
        repeat (2000) begin
            @(negedge sys_clk);
            pwm_cnt += int'(audio_pwm);
            on_cnt  += int'(seq_rst_n | amp_en);
            drive_random(1'b0);
        end
        sb_check(pwm_cnt);
        sb_check(on_cnt);

        // Fade-in from silence
        melody_in = 1'b0; bass_in = 1'b0; sfx_in = 1'b0; sfx_active = 1'b0;
        master_vol = 8'd255;
        @(negedge sys_clk);
        sb_push("fade_in_entry", CTL_FADE_IN, CTL_FADE_IN);
        pulse(1'b1, 1'b0);
        sb_check(ctl());
        sb_push("fade_in_len", 1019, 1021);
        wait_state(2'd2, 1200, n);
        sb_check(n);
        sb_push("play_ctl", CTL_PLAY, CTL_PLAY);
        sb_check(ctl());

        // Mix levels in PLAY
        mix_case("mix_melody",      1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 508, 520);
        mix_case("mix_bass",        1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 254, 520);
        mix_case("mix_both_vol200", 1'b1, 1'b1, 1'b0, 1'b0, 8'd200, 597, 520);
        mix_case("duck_sfx",        1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 382, 520);
        mix_case("duck_release",    1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 508, 515);

        // Full fade-out from PLAY
        sb_push("stop_from_play", CTL_FADE_OUT, CTL_FADE_OUT);
        pulse(1'b0, 1'b1);
        sb_check(ctl());
        sb_push("fade_out_len", 1019, 1021);
        wait_state(2'd0, 1200, n);
        sb_check(n);

        // Abort a fade-in at fade_level=100
        sb_push("abort_entry", CTL_FADE_IN, CTL_FADE_IN);
        pulse(1'b1, 1'b0);
        sb_check(ctl());
        repeat (400) @(negedge sys_clk);
        sb_push("abort_ctl", CTL_FADE_OUT, CTL_FADE_OUT);
        pulse(1'b0, 1'b1);
        sb_check(ctl());
        sb_push("abort_len", 396, 404);
        wait_state(2'd0, 600, n);
        sb_check(n);
        sb_push("abort_idle_outs", 0, 0);
        sb_check(outs_all());
        sfx_in = 1'b1;
        sb_push("idle_pwm_with_sfx", 0, 0);
        count_pwm(300, pwm_cnt);
        sb_check(pwm_cnt);
        sfx_in = 1'b0;

        // Request collisions
        sb_push("collide_idle", 0, 0);
        pulse(1'b1, 1'b1);
        sb_check(ctl());
        pulse(1'b1, 1'b0);
        wait_state(2'd2, 1200, n);
        sb_push("collide_play", CTL_FADE_OUT, CTL_FADE_OUT);
        pulse(1'b1, 1'b1);
        sb_check(ctl());
        repeat (10) @(negedge sys_clk);
        sb_push("refade_in", CTL_FADE_IN, CTL_FADE_IN);
        pulse(1'b1, 1'b0);
        sb_check(ctl());
        repeat (10) @(negedge sys_clk);
        sb_push("refade_out", CTL_FADE_OUT, CTL_FADE_OUT);
        pulse(1'b0, 1'b1);
        sb_check(ctl());
        repeat (5) @(negedge sys_clk);

        // Asynchronous reset mid-FADE_OUT, observed before the next clock edge
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        sb_push("async_reset_outs", 0, 0);
        sb_check(outs_all());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
